// File: rtl/set_event_pkg.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// Module      : set_event_pkg
// Description : Shared command and state encodings for the set-event stimulus
//               driver and the sequencer that decodes scenario commands.
// Revision    : 1.0 - initial release
// ============================================================================
package set_event_pkg;

    // Command encoding carried on i_cmd.
    typedef enum logic [1:0] {
        CMD_SET     = 2'b00,
        CMD_PULSE   = 2'b01,
        CMD_TOGGLE  = 2'b10,
        CMD_ILLEGAL = 2'b11
    } cmd_t;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_t;

endpackage : set_event_pkg
`default_nettype wire

// File: rtl/set_event_tb.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// Module      : set_event_tb
// Description : Stimulus driver that sets, pulses or toggles one of SET_SIZE
//               output signals on command after a programmable cycle delay,
//               reporting completion with a one-cycle done pulse.
// Ports       : clk, rst_n (sync, active-low)
//               i_en_set_event - start strobe
//               i_set_sel      - target index (0..SET_SIZE-1)
//               i_cmd          - 00 SET, 01 PULSE, 10 TOGGLE, 11 illegal
//               i_set_value    - value applied by SET / PULSE
//               i_delay        - cycles to wait before applying the command
//               i_pulse_len    - PULSE hold length (0 behaves as 1)
//               o_set          - driven signals (unpacked array)
//               o_busy         - command in progress
//               o_set_done     - one-cycle completion pulse
//               o_error        - one-cycle pulse on a rejected strobe
// Revision    : 1.0 - initial release
// ============================================================================
module set_event_tb
    import set_event_pkg::*;
#(
    parameter int SET_SIZE   = 5,
    parameter int SET_WIDTH  = 1,
    parameter int CLK_PERIOD = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en_set_event,
    input  int                   i_set_sel,
    input  logic [1:0]           i_cmd,
    input  logic [SET_WIDTH-1:0] i_set_value,
    input  logic [31:0]          i_delay,
    input  logic [31:0]          i_pulse_len,
    output logic [SET_WIDTH-1:0] o_set [SET_SIZE],
    output logic                 o_busy,
    output logic                 o_set_done,
    output logic                 o_error
);

    localparam int         c_SEL_W     = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1;
    localparam logic [1:0] c_ST_IDLE   = IDLE;
    localparam logic [1:0] c_ST_DELAY  = DELAY;
    localparam logic [1:0] c_ST_PULSE  = PULSE;

    logic [1:0]           r_state;
    logic [31:0]          r_cnt;
    logic [c_SEL_W-1:0]   r_sel;
    cmd_t                 r_cmd;
    logic [SET_WIDTH-1:0] r_value;
    logic [31:0]          r_delay;
    logic [31:0]          r_pulse_tgt;
    logic [SET_WIDTH-1:0] r_saved;
    logic [SET_WIDTH-1:0] r_set [SET_SIZE];
    logic                 r_done;
    logic                 r_error;
    logic                 w_reject;

    // A strobe in IDLE is refused for an out-of-range index or the illegal
    // command code; i_set_sel is a signed int so negatives are caught too.
    assign w_reject = (i_set_sel < 0) || (i_set_sel >= SET_SIZE) ||
                      (cmd_t'(i_cmd) == CMD_ILLEGAL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_cmd       <= CMD_SET;
            r_value     <= '0;
            r_delay     <= '0;
            r_pulse_tgt <= '0;
            r_saved     <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            for (int i = 0; i < SET_SIZE; i++) begin
                r_set[i] <= '0;
            end
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;

            // Strobes while a command is active are refused; the active
            // command carries on untouched.
            if (i_en_set_event && (r_state != c_ST_IDLE)) begin
                r_error <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (i_en_set_event) begin
                        if (w_reject) begin
                            r_error <= 1'b1;
                        end else begin
                            r_sel       <= i_set_sel[c_SEL_W-1:0];
                            r_cmd       <= cmd_t'(i_cmd);
                            r_value     <= i_set_value;
                            r_delay     <= i_delay;
                            // Store the terminal count so a zero length
                            // still yields a one-cycle pulse.
                            r_pulse_tgt <= (i_pulse_len == 32'd0) ? 32'd0
                                                                  : i_pulse_len - 32'd1;
                            r_cnt       <= '0;
                            r_state     <= c_ST_DELAY;
                        end
                    end
                end

                c_ST_DELAY: begin
                    // Exact compare: the counter never needs to wrap, so an
                    // all-ones delay is legal.
                    if (r_cnt == r_delay) begin
                        case (r_cmd)
                            CMD_SET: begin
                                r_set[r_sel] <= r_value;
                                r_done       <= 1'b1;
                                r_state      <= c_ST_IDLE;
                            end
                            CMD_TOGGLE: begin
                                r_set[r_sel] <= ~r_set[r_sel];
                                r_done       <= 1'b1;
                                r_state      <= c_ST_IDLE;
                            end
                            CMD_PULSE: begin
                                r_saved      <= r_set[r_sel];
                                r_set[r_sel] <= r_value;
                                r_cnt        <= '0;
                                r_state      <= c_ST_PULSE;
                            end
                            default: begin
                                r_state <= c_ST_IDLE;
                            end
                        endcase
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                c_ST_PULSE: begin
                    if (r_cnt == r_pulse_tgt) begin
                        r_set[r_sel] <= r_saved;
                        r_done       <= 1'b1;
                        r_state      <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_set      = r_set;
    assign o_busy     = (r_state != c_ST_IDLE);
    assign o_set_done = r_done;
    assign o_error    = r_error;

`ifndef SYNTHESIS
    // Log lines for scenario timestamps; cycle number derived from the
    // nominal clock period.
    always @(posedge clk) begin
        if (rst_n && r_done) begin
            $display("%t set_event_tb: command done on index %0d (cycle %0d)",
                     $time, r_sel, $time / CLK_PERIOD);
        end
        if (rst_n && r_error) begin
            $display("%t set_event_tb: strobe rejected (cycle %0d)",
                     $time, $time / CLK_PERIOD);
        end
    end
`endif

endmodule : set_event_tb
`default_nettype wire

// File: tb/tb_set_event_tb.sv
`timescale 1ps/1ps
`default_nettype none
// ============================================================================
// Module      : tb_set_event_tb
// Description : Self-checking bench for set_event_tb. Expected completions are
//               queued when a command is issued and popped when o_set_done
//               is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_set_event_tb;
    import set_event_pkg::*;

    localparam int c_SIZE   = 5;
    localparam int c_PERIOD = 1000;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        i_en        = 1'b0;
    int          i_sel       = 0;
    logic [1:0]  i_cmd       = 2'b00;
    logic [0:0]  i_value     = 1'b0;
    logic [31:0] i_delay     = '0;
    logic [31:0] i_plen      = '0;
    logic [0:0]  w_set [c_SIZE];
    logic        w_busy;
    logic        w_done;
    logic        w_error;

    set_event_tb #(
        .SET_SIZE   (c_SIZE),
        .SET_WIDTH  (1),
        .CLK_PERIOD (c_PERIOD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_en_set_event (i_en),
        .i_set_sel      (i_sel),
        .i_cmd          (i_cmd),
        .i_set_value    (i_value),
        .i_delay        (i_delay),
        .i_pulse_len    (i_plen),
        .o_set          (w_set),
        .o_busy         (w_busy),
        .o_set_done     (w_done),
        .o_error        (w_error)
    );

    always #(c_PERIOD/2) clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } exp_t;

    exp_t       sb [$];
    logic [4:0] model = '0;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [4:0] get_vec();
        logic [4:0] v;
        for (int i = 0; i < c_SIZE; i++) v[i] = w_set[i][0];
        return v;
    endfunction

    // Drive a strobe at the current falling edge; t is the sampling edge.
    task automatic issue(input int s, input logic [1:0] c, input logic v,
                         input logic [31:0] d, input logic [31:0] p, output int t);
        i_sel   = s;
        i_cmd   = c;
        i_value = v;
        i_delay = d;
        i_plen  = p;
        i_en    = 1'b1;
        t       = cyc + 1;
        @(negedge clk);
        i_en    = 1'b0;
    endtask

    // Wait (bounded) for o_set_done; at = -1 on timeout.
    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (w_done) begin
                at = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (get_vec() !== 5'b0) begin
            errors++; $display("FAIL reset_set: got %b expected %b", get_vec(), 5'b0);
        end
        checks++;
        if ({w_busy, w_done, w_error} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {w_busy, w_done, w_error});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({w_busy, w_done, w_error} !== 3'b000) begin
            errors++; $display("FAIL post_reset_flags: got %b expected 000", {w_busy, w_done, w_error});
        end
    endtask

    task automatic test_set();
        int t, at;
        exp_t e;
        issue(2, CMD_SET, 1'b1, 32'd0, 32'd0, t);
        model[2] = 1'b1;
        sb.push_back('{t + 1, model});
        checks++;
        if (w_busy !== 1'b1) begin
            errors++; $display("FAIL set_busy: got %b expected 1", w_busy);
        end
        wait_done(20, at);
        e = sb.pop_front();
        checks++;
        if (at !== e.cyc) begin
            errors++; $display("FAIL set_done_cycle: got %0d expected %0d", at, e.cyc);
        end
        checks++;
        if (get_vec() !== e.vec) begin
            errors++; $display("FAIL set_value: got %b expected %b", get_vec(), e.vec);
        end
        @(negedge clk);
        checks++;
        if ({w_busy, w_done} !== 2'b00) begin
            errors++; $display("FAIL set_one_cycle: got busy/done %b expected 00", {w_busy, w_done});
        end
    endtask

    task automatic test_pulse();
        int dly [2] = '{3, 0};
        int pl  [2] = '{4, 0};
        int len [2] = '{4, 1};
        for (int r = 0; r < 2; r++) begin
            int   t, rise, fall;
            exp_t e;
            issue(0, CMD_PULSE, 1'b1, dly[r], pl[r], t);
            rise = t + 1 + dly[r];
            fall = rise + len[r];
            sb.push_back('{fall, model});
            for (int k = 0; k <= 1 + dly[r] + len[r] + 1; k++) begin
                logic exp_bit;
                exp_bit = (cyc >= rise) && (cyc < fall);
                checks++;
                if (w_set[0][0] !== exp_bit) begin
                    errors++; $display("FAIL pulse%0d_level cyc=%0d: got %b expected %b",
                                       r, cyc, w_set[0][0], exp_bit);
                end
                checks++;
                if (w_done !== (cyc == fall)) begin
                    errors++; $display("FAIL pulse%0d_done cyc=%0d: got %b expected %b",
                                       r, cyc, w_done, (cyc == fall));
                end
                if (w_done && sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (get_vec() !== e.vec) begin
                        errors++; $display("FAIL pulse%0d_restore: got %b expected %b", r, get_vec(), e.vec);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t, at;
        exp_t e;
        for (int r = 0; r < 2; r++) begin
            issue(4, CMD_TOGGLE, 1'b0, 32'd2, 32'd0, t);
            model[4] = ~model[4];
            sb.push_back('{t + 3, model});
            wait_done(20, at);
            e = sb.pop_front();
            checks++;
            if (at !== e.cyc) begin
                errors++; $display("FAIL toggle%0d_cycle: got %0d expected %0d", r, at, e.cyc);
            end
            checks++;
            if (get_vec() !== e.vec) begin
                errors++; $display("FAIL toggle%0d_value: got %b expected %b", r, get_vec(), e.vec);
            end
            // Next strobe goes out on this same falling edge.
        end
        @(negedge clk);
        checks++;
        if (w_error !== 1'b0) begin
            errors++; $display("FAIL toggle_no_error: got %b expected 0", w_error);
        end
    endtask

    task automatic test_errors();
        int t, tb2, at;
        exp_t e;
        issue(5, CMD_SET, 1'b1, 32'd0, 32'd0, t);
        checks++;
        if ({w_error, w_busy} !== 2'b10) begin
            errors++; $display("FAIL err_range: got error/busy %b expected 10", {w_error, w_busy});
        end
        @(negedge clk);
        checks++;
        if ({w_error, get_vec()} !== {1'b0, model}) begin
            errors++; $display("FAIL err_range_after: got %b expected %b", {w_error, get_vec()}, {1'b0, model});
        end
        issue(0, 2'b11, 1'b1, 32'd0, 32'd0, t);
        checks++;
        if ({w_error, w_busy} !== 2'b10) begin
            errors++; $display("FAIL err_cmd: got error/busy %b expected 10", {w_error, w_busy});
        end
        @(negedge clk);
        checks++;
        if ({w_error, get_vec()} !== {1'b0, model}) begin
            errors++; $display("FAIL err_cmd_after: got %b expected %b", {w_error, get_vec()}, {1'b0, model});
        end
        issue(3, CMD_SET, 1'b1, 32'd10, 32'd0, t);
        model[3] = 1'b1;
        sb.push_back('{t + 11, model});
        repeat (3) @(negedge clk);
        issue(1, CMD_SET, 1'b1, 32'd0, 32'd0, tb2);
        checks++;
        if ({w_error, w_busy} !== 2'b11) begin
            errors++; $display("FAIL err_busy: got error/busy %b expected 11", {w_error, w_busy});
        end
        wait_done(30, at);
        e = sb.pop_front();
        checks++;
        if (at !== e.cyc) begin
            errors++; $display("FAIL err_busy_done_cycle: got %0d expected %0d", at, e.cyc);
        end
        checks++;
        if (get_vec() !== e.vec) begin
            errors++; $display("FAIL err_busy_value: got %b expected %b", get_vec(), e.vec);
        end
    endtask

    task automatic test_reset_abort();
        int t, at;
        int saw_done;
        exp_t e;
        issue(1, CMD_PULSE, 1'b1, 32'd2, 32'd20, t);
        while (cyc < t + 5) @(negedge clk);
        checks++;
        if (get_vec() !== (model | 5'b00010)) begin
            errors++; $display("FAIL abort_pulse_active: got %b expected %b", get_vec(), model | 5'b00010);
        end
        while (cyc < t + 7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model = '0;
        checks++;
        if ({get_vec(), w_busy, w_done} !== 7'b0) begin
            errors++; $display("FAIL abort_reset: got set/busy/done %b expected 0", {get_vec(), w_busy, w_done});
        end
        rst_n    = 1'b1;
        saw_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (w_done) saw_done++;
        end
        checks++;
        if (saw_done !== 0 || get_vec() !== 5'b0) begin
            errors++; $display("FAIL abort_no_done: got done count %0d set %b expected 0 and 00000",
                               saw_done, get_vec());
        end
        issue(3, CMD_SET, 1'b1, 32'd1, 32'd0, t);
        model[3] = 1'b1;
        sb.push_back('{t + 2, model});
        wait_done(20, at);
        e = sb.pop_front();
        checks++;
        if (at !== e.cyc || get_vec() !== e.vec) begin
            errors++; $display("FAIL abort_recover: got cycle %0d set %b expected cycle %0d set %b",
                               at, get_vec(), e.cyc, e.vec);
        end
    endtask

    task automatic test_long_delay();
        int t, rise, at;
        exp_t e;
        issue(2, CMD_SET, 1'b1, 32'd50, 32'd0, t);
        model[2] = 1'b1;
        sb.push_back('{t + 51, model});
        rise = -1;
        at   = -1;
        for (int k = 0; k < 80 && at < 0; k++) begin
            if (w_set[2][0] && rise < 0) rise = cyc;
            if (w_done) at = cyc;
            else @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if (rise !== e.cyc) begin
            errors++; $display("FAIL long_rise_cycle: got %0d expected %0d", rise, e.cyc);
        end
        checks++;
        if (at !== e.cyc || get_vec() !== e.vec) begin
            errors++; $display("FAIL long_done: got cycle %0d set %b expected cycle %0d set %b",
                               at, get_vec(), e.cyc, e.vec);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_set();
        test_pulse();
        test_back_to_back();
        test_errors();
        test_reset_abort();
        test_long_delay();
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_set_event_tb
`default_nettype wire
